dec_pingpong_ram: RTL

Parametrised, multi-channel hard-decision store with ping-pong (double-buffered) frame pages. The LDPC decoder core writes and reads hard decisions for the current frame through NUM_CH independent single-port channels on the active page. The previously completed frame is streamed out of the inactive page over a valid/ready interface. It sits between the decoder's variable-node update stage and the decoded-bit output path, so decoding frame k+1 overlaps with unloading frame k.

---
 rtl/dec_pingpong_ram_if.sv | 33 +++
 rtl/dec_pingpong_ram.sv | 119 +++++++++++
 2 files changed

// File: rtl/dec_pingpong_ram_if.sv
// Decoder-side channel bus, page handshake and unload stream of the ping-pong
// hard-decision store, bundled so the store and its users share one port list.
interface dec_pingpong_ram_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 2
);
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] address;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]                 we;
    logic [NUM_CH-1:0]                 cs;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_out;

    logic                              frame_done;
    logic                              swap_ready;
    logic                              page_sel;
    logic                              frame_ovf;

    logic                              out_valid;
    logic                              out_ready;
    logic [NUM_CH*DATA_WIDTH-1:0]      out_data;
    logic                              out_last;

    modport master (
        output address, data_in, we, cs, frame_done, out_ready,
        input  data_out, swap_ready, page_sel, frame_ovf, out_valid, out_data, out_last
    );

    modport slave (
        input  address, data_in, we, cs, frame_done, out_ready,
        output data_out, swap_ready, page_sel, frame_ovf, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dec_pingpong_ram.sv
// Double-buffered multi-channel hard-decision store: the decoder owns page
// page_sel while the previous frame is streamed out of the other page.
//
//   state | meaning
//   IDLE  | inactive page free, frame_done accepted (swap_ready=1)
//   FETCH | reading word ua from every channel of the inactive page
//   HOLD  | unload word presented, waiting for out_ready
module dec_pingpong_ram #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_CH     = 2
) (
    input logic               clk,
    input logic               reset,
    dec_pingpong_ram_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0]             mem [2][NUM_CH][RAM_DEPTH];
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] dout;

    state_t                            state;
    logic [ADDR_WIDTH-1:0]             ua;
    logic                              page;
    logic                              ovf;
    logic                              ready_idle;
    logic                              valid;
    logic                              last;
    logic [NUM_CH*DATA_WIDTH-1:0]      word;

    // Decoder writes; no access while reset is held
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset && bus.cs[c] && bus.we[c]) begin
                mem[page][c][bus.address[c]] <= bus.data_in[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.cs[c] && !bus.we[c]) begin
                    dout[c] <= mem[page][c][bus.address[c]];
                end
            end
        end
    end

    // Unload side always works on the page the decoder does not own
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ua         <= '0;
            page       <= 1'b0;
            ovf        <= 1'b0;
            ready_idle <= 1'b1;
            valid      <= 1'b0;
            last       <= 1'b0;
            word       <= '0;
        end else begin
            if (bus.frame_done && state != IDLE) begin
                ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.frame_done) begin
                        page       <= ~page;
                        ua         <= '0;
                        ready_idle <= 1'b0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        word[c*DATA_WIDTH +: DATA_WIDTH] <= mem[~page][c][ua];
                    end
                    last  <= (ua == LAST_ADDR);
                    valid <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid <= 1'b0;
                        if (last) begin
                            ready_idle <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            ua    <= ua + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    valid      <= 1'b0;
                    ready_idle <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = dout;
    assign bus.swap_ready = ready_idle;
    assign bus.page_sel   = page;
    assign bus.frame_ovf  = ovf;
    assign bus.out_valid  = valid;
    assign bus.out_data   = word;
    assign bus.out_last   = last;
endmodule
